// File: rtl/toast_branch_ctrl_if.sv
// toast_branch_ctrl_if: redirect handshake between the EX-stage branch
// controller (master) and the instruction fetch unit (slave).
// The controller drives a new fetch PC with a valid flag and IF answers
// with ready; the PC is held stable until the handshake completes.
interface toast_branch_ctrl_if;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;

    modport master (
        output redirect_valid_o,
        output redirect_pc_o,
        input  redirect_ready_i
    );

    modport slave (
        input  redirect_valid_o,
        input  redirect_pc_o,
        output redirect_ready_i
    );
endinterface

// File: rtl/toast_branch_ctrl.sv
// toast_branch_ctrl: EX-stage branch/jump resolution controller.
// Evaluates the branch condition, feeds the operands to toast_branchgen,
// registers the computed target and hands it to IF over the redirect
// handshake, stalling EX while the redirect waits and flushing IF/ID until
// FLUSH_CYCLES cycles after it has been accepted.
// Optional feature: define TOAST_BRANCH_MISALIGN_EN to add misalign_o, a
// registered one-cycle pulse raised instead of a redirect when a taken
// target is not word aligned.
module toast_branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32,
    // Encoding of the register-relative (JALR style) branchgen operation;
    // must match REG_OFFSET in toast_definitions.vh.
    parameter logic [1:0]  REG_OFFSET   = 2'b01
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                ex_valid_i,
    input  logic                ex_jump_i,
    input  logic                ex_branch_i,
    input  logic [1:0]          ex_branch_op_i,
    input  logic [2:0]          ex_funct3_i,
    input  logic [31:0]         ex_pc_i,
    input  logic [31:0]         ex_rs1_i,
    input  logic [31:0]         ex_rs2_i,
    input  logic [31:0]         ex_imm_i,

    output logic [1:0]          bg_op_o,
    output logic [31:0]         bg_pc_o,
    output logic [31:0]         bg_regdata_o,
    output logic [31:0]         bg_imm_o,
    input  logic [31:0]         bg_dest_i,

    toast_branch_ctrl_if.master redir_if,

    output logic                stall_o,
    output logic                flush_o,
    output logic [31:0]         link_o,
    output logic [CNT_W-1:0]    taken_cnt_o
`ifdef TOAST_BRANCH_MISALIGN_EN
    ,
    output logic                misalign_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Value loaded into the flush down-counter; FLUSH_CYCLES is limited to
    // 1..7 so three bits always suffice.
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t             state_q;
    logic               redirValid_q;
    logic [31:0]        redirPc_q;
    logic               stall_q;
    logic               flush_q;
    logic [2:0]         flushCnt_q;
    logic [CNT_W-1:0]   takenCnt_q;
`ifdef TOAST_BRANCH_MISALIGN_EN
    logic               misalign_q;
`endif

    logic               condMet;
    logic               isJalr;
    logic               take;
    logic               badTarget;
    logic [31:0]        target_d;

    // Branchgen operands are a straight combinational mirror of EX, so the
    // target is available in the same cycle the condition is evaluated.
    always_comb begin
        bg_op_o      = ex_branch_op_i;
        bg_pc_o      = ex_pc_i;
        bg_regdata_o = ex_rs1_i;
        bg_imm_o     = ex_imm_i;
        link_o       = ex_pc_i + 32'd4;
    end

    // Branch condition decode from funct3; the two reserved codes never take.
    always_comb begin
        condMet = 1'b0;
        case (ex_funct3_i)
            3'b000:  condMet = (ex_rs1_i == ex_rs2_i);
            3'b001:  condMet = (ex_rs1_i != ex_rs2_i);
            3'b100:  condMet = ($signed(ex_rs1_i) <  $signed(ex_rs2_i));
            3'b101:  condMet = ($signed(ex_rs1_i) >= $signed(ex_rs2_i));
            3'b110:  condMet = (ex_rs1_i <  ex_rs2_i);
            3'b111:  condMet = (ex_rs1_i >= ex_rs2_i);
            default: condMet = 1'b0;
        endcase
    end

    // Take decision and target shaping: a jump wins over a branch when both
    // are flagged, and JALR targets have bit 0 cleared.
    always_comb begin
        isJalr    = ex_jump_i && (ex_branch_op_i == REG_OFFSET);
        take      = ex_valid_i && (state_q == IDLE) &&
                    (ex_jump_i || (ex_branch_i && condMet));
        target_d  = isJalr ? {bg_dest_i[31:1], 1'b0} : bg_dest_i;
`ifdef TOAST_BRANCH_MISALIGN_EN
        badTarget = (target_d[1:0] != 2'b00);
`else
        badTarget = 1'b0;
`endif
    end

    // Redirect sequencer with registered handshake, stall and flush outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            redirValid_q <= 1'b0;
            redirPc_q    <= 32'd0;
            stall_q      <= 1'b0;
            flush_q      <= 1'b0;
            flushCnt_q   <= 3'd0;
            takenCnt_q   <= '0;
`ifdef TOAST_BRANCH_MISALIGN_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
`ifdef TOAST_BRANCH_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (take) begin
                        if (badTarget) begin
`ifdef TOAST_BRANCH_MISALIGN_EN
                            misalign_q <= 1'b1;
`endif
                        end else begin
                            redirPc_q    <= target_d;
                            redirValid_q <= 1'b1;
                            stall_q      <= 1'b1;
                            flush_q      <= 1'b1;
                            state_q      <= REDIR;
                        end
                    end
                end
                REDIR: begin
                    if (redir_if.redirect_ready_i) begin
                        redirValid_q <= 1'b0;
                        stall_q      <= 1'b0;
                        takenCnt_q   <= takenCnt_q + 1'b1;
                        flushCnt_q   <= FLUSH_LAST;
                        state_q      <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flushCnt_q == 3'd0) begin
                        flush_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        flushCnt_q <= flushCnt_q - 3'd1;
                    end
                end
                default: begin
                    redirValid_q <= 1'b0;
                    stall_q      <= 1'b0;
                    flush_q      <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign redir_if.redirect_valid_o = redirValid_q;
    assign redir_if.redirect_pc_o    = redirPc_q;
    assign stall_o                   = stall_q;
    assign flush_o                   = flush_q;
    assign taken_cnt_o               = takenCnt_q;
`ifdef TOAST_BRANCH_MISALIGN_EN
    assign misalign_o                = misalign_q;
`endif

endmodule

// File: tb/tb_toast_branch_ctrl.sv
// tb_toast_branch_ctrl: directed vectors for toast_branch_ctrl with a
// queue-based scoreboard; a negedge monitor pops an expected redirect
// whenever the DUT completes a redirect handshake.
`timescale 1ns/1ps
module tb_toast_branch_ctrl;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam logic [1:0]  PC_REL       = 2'b00;
    localparam logic [1:0]  REG_OFF      = 2'b01;
`ifdef TOAST_BRANCH_MISALIGN_EN
    localparam logic        MIS_EN       = 1'b1;
`else
    localparam logic        MIS_EN       = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        exValid, exJump, exBranch;
    logic [1:0]  exOp;
    logic [2:0]  exF3;
    logic [31:0] exPc, exRs1, exRs2, exImm;
    logic [1:0]  bgOp;
    logic [31:0] bgPc, bgRegdata, bgImm, bgDest;
    logic        stall, flush;
    logic [31:0] link;
    logic [31:0] takenCnt;
`ifdef TOAST_BRANCH_MISALIGN_EN
    logic        misalign;
`endif

    toast_branch_ctrl_if redirIf ();

    toast_branch_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (32),
        .REG_OFFSET   (REG_OFF)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ex_valid_i     (exValid),
        .ex_jump_i      (exJump),
        .ex_branch_i    (exBranch),
        .ex_branch_op_i (exOp),
        .ex_funct3_i    (exF3),
        .ex_pc_i        (exPc),
        .ex_rs1_i       (exRs1),
        .ex_rs2_i       (exRs2),
        .ex_imm_i       (exImm),
        .bg_op_o        (bgOp),
        .bg_pc_o        (bgPc),
        .bg_regdata_o   (bgRegdata),
        .bg_imm_o       (bgImm),
        .bg_dest_i      (bgDest),
        .redir_if       (redirIf),
        .stall_o        (stall),
        .flush_o        (flush),
        .link_o         (link),
        .taken_cnt_o    (takenCnt)
`ifdef TOAST_BRANCH_MISALIGN_EN
        ,
        .misalign_o     (misalign)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for toast_branchgen: base (pc or register) plus immediate.
    always_comb bgDest = ((bgOp == REG_OFF) ? bgRegdata : bgPc) + bgImm;

    typedef struct {
        logic [31:0] pc;
        int          validCycles;
        logic [31:0] cnt;
    } expRedir_t;

    typedef struct {
        logic        jump;
        logic        branch;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        expTaken;
        logic        expMis;
        logic [31:0] expPc;
    } vec_t;

    expRedir_t   sbQueue[$];
    vec_t        vecs[$];
    string       vecNames[$];
    int          vectorsApplied = 0;
    int          miscompares    = 0;
    logic [31:0] expCnt         = 32'd0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: tracks one redirect from first valid cycle through end of flush.
    logic        monBusy   = 1'b0;
    logic        postHs    = 1'b0;
    logic        firstPost = 1'b0;
    logic        pcMoved   = 1'b0;
    int          mValid, mStall, mFlush, mExpValid;
    logic [31:0] heldPc, mExpCnt;

    always @(negedge clk) begin
        expRedir_t e;
        if (rst) begin
            monBusy = 1'b0;
            postHs  = 1'b0;
        end else if (redirIf.redirect_valid_o) begin
            if (!monBusy) begin
                monBusy = 1'b1;
                postHs  = 1'b0;
                mValid  = 0;
                mStall  = 0;
                mFlush  = 0;
                pcMoved = 1'b0;
                heldPc  = redirIf.redirect_pc_o;
            end
            mValid++;
            if (stall) mStall++;
            if (flush) mFlush++;
            if (redirIf.redirect_pc_o !== heldPc) pcMoved = 1'b1;
            if (redirIf.redirect_ready_i) begin
                if (sbQueue.size() == 0) begin
                    vectorsApplied++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_redirect: actual pc=0x%08h expected none", redirIf.redirect_pc_o);
                    monBusy = 1'b0;
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("redirect_pc", redirIf.redirect_pc_o, e.pc);
                    checkOutput("valid_cycles", mValid, e.validCycles);
                    checkOutput("stall_cycles", mStall, e.validCycles);
                    checkOutput("pc_stable", {31'd0, pcMoved}, 32'd0);
                    mExpValid = e.validCycles;
                    mExpCnt   = e.cnt;
                    postHs    = 1'b1;
                    firstPost = 1'b1;
                end
            end
        end else if (postHs) begin
            if (firstPost) begin
                checkOutput("taken_cnt", takenCnt, mExpCnt);
                checkOutput("stall_in_flush", {31'd0, stall}, 32'd0);
                firstPost = 1'b0;
            end
            if (flush) begin
                mFlush++;
            end else begin
                checkOutput("flush_cycles", mFlush, mExpValid + FLUSH_CYCLES);
                postHs  = 1'b0;
                monBusy = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input string name, input int expValid);
        exJump   = v.jump;
        exBranch = v.branch;
        exOp     = v.op;
        exF3     = v.f3;
        exPc     = v.pc;
        exRs1    = v.rs1;
        exRs2    = v.rs2;
        exImm    = v.imm;
        exValid  = 1'b1;
        #1;
        checkOutput({name, "_link"}, link, v.pc + 32'd4);
        if (v.expTaken && !v.expMis) begin
            expCnt = expCnt + 32'd1;
            sbQueue.push_back('{v.expPc, expValid, expCnt});
        end
        @(posedge clk); #1;
        exValid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!monBusy && !redirIf.redirect_valid_o && !flush) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            vectorsApplied++;
            miscompares++;
            $display("[TB] FAIL %s_timeout: actual=busy expected=idle within 40 cycles", name);
        end
    endtask

    task automatic checkQuiet(input string name);
        for (int i = 0; i < 2; i++) begin
            checkOutput({name, "_valid"}, {31'd0, redirIf.redirect_valid_o}, 32'd0);
            checkOutput({name, "_stall"}, {31'd0, stall}, 32'd0);
            checkOutput({name, "_flush"}, {31'd0, flush}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        exValid = 1'b0; exJump = 1'b0; exBranch = 1'b0; exOp = PC_REL; exF3 = 3'd0;
        exPc = 32'd0; exRs1 = 32'd0; exRs2 = 32'd0; exImm = 32'd0;
        redirIf.redirect_ready_i = 1'b1;

        // jump, branch, op, f3, pc, rs1, rs2, imm, taken, misaligned, target
        vecs.push_back('{1'b0, 1'b1, PC_REL,  3'b000, 32'h100, 32'd5,        32'd5, 32'h20,  1'b1, 1'b0,   32'h120});
        vecNames.push_back("beq_taken");
        vecs.push_back('{1'b0, 1'b1, PC_REL,  3'b100, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h40,  1'b1, 1'b0,   32'h240});
        vecNames.push_back("blt_taken");
        vecs.push_back('{1'b0, 1'b1, PC_REL,  3'b110, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h40,  1'b0, 1'b0,   32'h0});
        vecNames.push_back("bltu_not");
        vecs.push_back('{1'b1, 1'b0, REG_OFF, 3'b000, 32'h300, 32'h203,      32'd0, 32'h0,   1'b1, MIS_EN, 32'h202});
        vecNames.push_back("jalr");
        vecs.push_back('{1'b0, 1'b1, PC_REL,  3'b001, 32'h400, 32'd7,        32'd7, 32'h10,  1'b0, 1'b0,   32'h0});
        vecNames.push_back("bne_not");
        vecs.push_back('{1'b0, 1'b1, PC_REL,  3'b101, 32'h400, 32'h80000000, 32'd0, 32'h10,  1'b0, 1'b0,   32'h0});
        vecNames.push_back("bge_not");
        vecs.push_back('{1'b0, 1'b1, PC_REL,  3'b111, 32'h400, 32'h80000000, 32'd0, 32'h10,  1'b1, 1'b0,   32'h410});
        vecNames.push_back("bgeu_taken");
        vecs.push_back('{1'b0, 1'b1, PC_REL,  3'b010, 32'h400, 32'd3,        32'd3, 32'h10,  1'b0, 1'b0,   32'h0});
        vecNames.push_back("f3_010_not");
        vecs.push_back('{1'b1, 1'b1, PC_REL,  3'b000, 32'h500, 32'd1,        32'd2, 32'h100, 1'b1, 1'b0,   32'h600});
        vecNames.push_back("jump_and_branch");
        vecs.push_back('{1'b0, 1'b0, PC_REL,  3'b000, 32'h500, 32'd9,        32'd9, 32'h8,   1'b0, 1'b0,   32'h0});
        vecNames.push_back("no_ctrl_flow");
`ifdef TOAST_BRANCH_MISALIGN_EN
        vecs.push_back('{1'b1, 1'b0, PC_REL,  3'b000, 32'h100, 32'd0,        32'd0, 32'h6,   1'b1, 1'b1,   32'h106});
        vecNames.push_back("jal_misalign");
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", {31'd0, redirIf.redirect_valid_o}, 32'd0);
        checkOutput("rst_pc",    redirIf.redirect_pc_o, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_flush", {31'd0, flush}, 32'd0);
        checkOutput("rst_cnt",   takenCnt, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            applyStimulus(vecs[k], vecNames[k], 1);
            if (vecs[k].expTaken && !vecs[k].expMis) begin
                waitIdle(vecNames[k]);
            end else if (vecs[k].expTaken) begin
`ifdef TOAST_BRANCH_MISALIGN_EN
                checkOutput({vecNames[k], "_mis_hi"}, {31'd0, misalign}, 32'd1);
                checkQuiet(vecNames[k]);
                checkOutput({vecNames[k], "_mis_lo"}, {31'd0, misalign}, 32'd0);
`endif
            end else begin
                checkQuiet(vecNames[k]);
            end
        end

        // IF holds off the redirect; a second jump arriving meanwhile is ignored.
        redirIf.redirect_ready_i = 1'b0;
        applyStimulus('{1'b1, 1'b0, PC_REL, 3'b000, 32'h700, 32'd0, 32'd0, 32'h80, 1'b1, 1'b0, 32'h780},
                      "jal_stall", 6);
        @(posedge clk); #1;
        exValid = 1'b1; exJump = 1'b1; exPc = 32'h900; exImm = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        exValid = 1'b0; exJump = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirIf.redirect_ready_i = 1'b1;
        waitIdle("jal_stall");

        // Reset while a redirect is pending drops it and clears the counter.
        redirIf.redirect_ready_i = 1'b0;
        exJump = 1'b1; exBranch = 1'b0; exOp = PC_REL; exPc = 32'hA00; exImm = 32'h20;
        exValid = 1'b1;
        @(posedge clk); #1;
        exValid = 1'b0; exJump = 1'b0;
        checkOutput("pre_rst_valid", {31'd0, redirIf.redirect_valid_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expCnt = 32'd0;
        checkOutput("midrst_valid", {31'd0, redirIf.redirect_valid_o}, 32'd0);
        checkOutput("midrst_pc",    redirIf.redirect_pc_o, 32'd0);
        checkOutput("midrst_stall", {31'd0, stall}, 32'd0);
        checkOutput("midrst_flush", {31'd0, flush}, 32'd0);
        checkOutput("midrst_cnt",   takenCnt, 32'd0);
        redirIf.redirect_ready_i = 1'b1;
        @(posedge clk); #1;
        applyStimulus('{1'b1, 1'b0, PC_REL, 3'b000, 32'hB00, 32'd0, 32'd0, 32'h10, 1'b1, 1'b0, 32'hB10},
                      "post_rst_jal", 1);
        waitIdle("post_rst_jal");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", sbQueue.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
